// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered result/NZCV flags and an
// iterative shift-add multiplier that stalls the input side while busy.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [SHW:0]   WID_L    = (SHW + 1)'(WIDTH);

  state_t                 state_r;
  state_t                 state_s;
  logic [SHW-1:0]         cnt_r;
  logic [2*WIDTH-1:0]     mcand_r;
  logic [WIDTH-1:0]       mplier_r;
  logic [2*WIDTH-1:0]     acc_r;
  logic [2*WIDTH-1:0]     prod_s;
  logic                   accept_s;
  logic                   is_mul_s;
  logic                   last_s;

  logic [WIDTH:0]         sum_s;
  logic [WIDTH:0]         dif_s;
  logic [WIDTH:0]         lsl_s;
  logic [WIDTH:0]         lsr_s;
  logic signed [WIDTH:0]  asr_s;
  logic [WIDTH-1:0]       ror_s;
  logic [WIDTH-1:0]       res_s;
  logic                   c_s;
  logic                   v_s;

  assign accept_s = in_valid & in_ready;
  assign is_mul_s = (op == 4'd10);
  assign last_s   = (state_r == BUSY) && (cnt_r == CNT_LAST);
  assign prod_s   = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});

  // Shifts use a one-bit extension so the last bit shifted out lands in a fixed slot.
  assign sum_s = {1'b0, a} + {1'b0, b};
  assign dif_s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign lsl_s = {1'b0, a} << shamt;
  assign lsr_s = {a, 1'b0} >> shamt;
  assign asr_s = $signed({a, 1'b0}) >>> shamt;
  assign ror_s = (a >> shamt) | (a << (WID_L - {1'b0, shamt}));

  // Single-cycle result and carry/overflow selection.
  always_comb begin
    res_s = a;
    c_s   = 1'b0;
    v_s   = 1'b0;
    case (op)
      4'd0: begin
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        res_s = dif_s[WIDTH-1:0];
        c_s   = dif_s[WIDTH];
        v_s   = (a[WIDTH-1] != b[WIDTH-1]) && (dif_s[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2: res_s = ~a;
      4'd3: res_s = a & b;
      4'd4: res_s = a | b;
      4'd5: res_s = a ^ b;
      4'd6: begin
        res_s = lsl_s[WIDTH-1:0];
        c_s   = lsl_s[WIDTH];
      end
      4'd7: begin
        res_s = lsr_s[WIDTH:1];
        c_s   = lsr_s[0];
      end
      4'd8: begin
        res_s = asr_s[WIDTH:1];
        c_s   = asr_s[0];
      end
      4'd9: begin
        res_s = ror_s;
        c_s   = (shamt != {SHW{1'b0}}) & ror_s[WIDTH-1];
      end
      default: res_s = a;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = is_mul_s ? BUSY : HOLD;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (last_s) begin
          state_s = HOLD;
        end else begin
          state_s = BUSY;
        end
      end
      HOLD: begin
        if (accept_s) begin
          state_s = is_mul_s ? BUSY : HOLD;
        end else if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b0;
    case (state_r)
      IDLE:    in_ready = ~rst;
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = ~rst & out_ready;
      end
      default: begin
        out_valid = 1'b0;
        in_ready  = 1'b0;
      end
    endcase
  end

  // Result/flag registers and multiplier datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= {WIDTH{1'b0}};
      flags    <= 4'b0000;
      cnt_r    <= {SHW{1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
    end else if (accept_s) begin
      if (is_mul_s) begin
        mcand_r  <= {{WIDTH{1'b0}}, a};
        mplier_r <= b;
        acc_r    <= {(2*WIDTH){1'b0}};
        cnt_r    <= {SHW{1'b0}};
      end else begin
        out   <= res_s;
        flags <= {res_s[WIDTH-1], (res_s == {WIDTH{1'b0}}), c_s, v_s};
      end
    end else if (state_r == BUSY) begin
      acc_r    <= prod_s;
      mcand_r  <= mcand_r << 1'b1;
      mplier_r <= mplier_r >> 1'b1;
      cnt_r    <= cnt_r + SHW'(1'b1);
      if (last_s) begin
        out   <= prod_s[WIDTH-1:0];
        flags <= {prod_s[WIDTH-1], (prod_s[WIDTH-1:0] == {WIDTH{1'b0}}),
                  (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}}), 1'b0};
      end
    end else begin
      out   <= out;
      flags <= flags;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8 and WIDTH=16 with hand-computed expectations.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b1;
  logic [7:0]  a8 = 8'h00, b8 = 8'h00, out8;
  logic [3:0]  op8 = 4'd0, fl8;
  logic [2:0]  sh8 = 3'd0;

  logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b1;
  logic [15:0] a16 = 16'h0000, b16 = 16'h0000, out16;
  logic [3:0]  op16 = 4'd0, fl16;
  logic [3:0]  sh16 = 4'd0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .op(op8), .shamt(sh8), .out_valid(ov8), .out_ready(or8), .out(out8), .flags(fl8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .op(op16), .shamt(sh16), .out_valid(ov16), .out_ready(or16), .out(out16), .flags(fl16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [2:0] s);
    op8 = o; a8 = x; b8 = y; sh8 = s; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
  endtask

  task automatic issue16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    op16 = o; a16 = x; b16 = y; sh16 = 4'd0; iv16 = 1'b1;
    tick();
    iv16 = 1'b0;
  endtask

  task automatic res8(input string tag, input logic [7:0] eo, input logic [3:0] ef);
    chk({tag, "_valid"}, {31'd0, ov8}, 32'd1);
    chk({tag, "_out"}, {24'd0, out8}, {24'd0, eo});
    chk({tag, "_flags"}, {28'd0, fl8}, {28'd0, ef});
  endtask

  initial begin
    // Reset behaviour
    tick();
    tick();
    chk("rst_in_ready", {31'd0, ir8}, 32'd0);
    chk("rst_out_valid", {31'd0, ov8}, 32'd0);
    chk("rst_out", {24'd0, out8}, 32'd0);
    chk("rst_flags", {28'd0, fl8}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, ir8}, 32'd1);

    // Single-cycle ops, issued back to back
    issue8(4'd0, 8'h7F, 8'h01, 3'd0); res8("add_ovf", 8'h80, 4'b1001);
    issue8(4'd1, 8'h05, 8'h05, 3'd0); res8("sub_eq", 8'h00, 4'b0110);
    issue8(4'd1, 8'h03, 8'h05, 3'd0); res8("sub_borrow", 8'hFE, 4'b1000);
    issue8(4'd0, 8'hFF, 8'h01, 3'd0); res8("add_carry", 8'h00, 4'b0110);
    issue8(4'd6, 8'h81, 8'h00, 3'd1); res8("lsl1", 8'h02, 4'b0010);
    issue8(4'd6, 8'h81, 8'h00, 3'd0); res8("lsl0", 8'h81, 4'b1000);
    issue8(4'd7, 8'h81, 8'h00, 3'd7); res8("lsr7", 8'h01, 4'b0000);
    issue8(4'd8, 8'h80, 8'h00, 3'd3); res8("asr3", 8'hF0, 4'b1000);
    issue8(4'd9, 8'h01, 8'h00, 3'd1); res8("ror1", 8'h80, 4'b1010);
    issue8(4'd9, 8'h81, 8'h00, 3'd0); res8("ror0", 8'h81, 4'b1000);
    issue8(4'd2, 8'h0F, 8'h00, 3'd0); res8("not", 8'hF0, 4'b1000);
    issue8(4'd3, 8'hCC, 8'hAA, 3'd0); res8("and", 8'h88, 4'b1000);
    issue8(4'd4, 8'h0C, 8'h0A, 3'd0); res8("orr", 8'h0E, 4'b0000);
    issue8(4'd5, 8'hFF, 8'hFF, 3'd0); res8("eor", 8'h00, 4'b0100);
    issue8(4'd12, 8'h5A, 8'h00, 3'd0); res8("pass", 8'h5A, 4'b0000);

    // Multiply: latency 8, operands captured at accept
    issue8(4'd10, 8'h10, 8'h11, 3'd0);
    a8 = 8'hFF; b8 = 8'hFF;
    for (int i = 1; i < 8; i++) begin
      chk("mul_busy_valid", {31'd0, ov8}, 32'd0);
      chk("mul_busy_ready", {31'd0, ir8}, 32'd0);
      tick();
    end
    chk("mul_busy_valid_last", {31'd0, ov8}, 32'd0);
    tick();
    res8("mul", 8'h10, 4'b0010);
    tick();
    chk("drain_idle", {31'd0, ov8}, 32'd0);

    // Reset in the middle of a multiply
    issue8(4'd10, 8'h03, 8'h03, 3'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_valid", {31'd0, ov8}, 32'd0);
    chk("mrst_out", {24'd0, out8}, 32'd0);
    chk("mrst_flags", {28'd0, fl8}, 32'd0);
    chk("mrst_ready_in_rst", {31'd0, ir8}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mrst_ready", {31'd0, ir8}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mrst_no_late", {31'd0, ov8}, 32'd0);
    end

    // Backpressure on a stream of ADDs
    issue8(4'd0, 8'h01, 8'h01, 3'd0);
    res8("bp_first", 8'h02, 4'b0000);
    or8 = 1'b0; a8 = 8'h02; b8 = 8'h02; iv8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_ready", {31'd0, ir8}, 32'd0);
      res8("bp_hold", 8'h02, 4'b0000);
    end
    or8 = 1'b1;
    tick();
    res8("bp_second", 8'h04, 4'b0000);
    a8 = 8'h03; b8 = 8'h03;
    tick();
    res8("bp_third", 8'h06, 4'b0000);
    iv8 = 1'b0;
    tick();
    chk("bp_drained", {31'd0, ov8}, 32'd0);

    // WIDTH=16 instance
    issue16(4'd1, 16'h0000, 16'h0001);
    chk("w16_sub_valid", {31'd0, ov16}, 32'd1);
    chk("w16_sub_out", {16'd0, out16}, 32'h0000FFFF);
    chk("w16_sub_flags", {28'd0, fl16}, 32'b1000);
    issue16(4'd10, 16'h0100, 16'h0100);
    for (int i = 1; i < 16; i++) begin
      chk("w16_mul_busy", {31'd0, ov16}, 32'd0);
      tick();
    end
    chk("w16_mul_busy_last", {31'd0, ov16}, 32'd0);
    tick();
    chk("w16_mul_valid", {31'd0, ov16}, 32'd1);
    chk("w16_mul_out", {16'd0, out16}, 32'h00000000);
    chk("w16_mul_flags", {28'd0, fl16}, 32'b0110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 8-bit datapath ALU. It performs one operation per transaction on WIDTH-bit operands and registers both the result and an NZCV flag set. It adds arithmetic/rotate shifts and an iterative shift-add multiplier. It sits between the operand-fetch stage and writeback, using valid/ready on both sides so the multi-cycle multiply can stall the pipeline.

## Interface
- WIDTH, 8: operand/result width, ≥ 2.
- SHW, $clog2(WIDTH): shift-amount width (derived; not overridden).
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand transaction offered.
- in_ready  out  1  block can accept; combinational from state and out_ready.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  4  operation select, encoding below.
- shamt  in  SHW  shift/rotate amount.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes result.
- out  out  WIDTH  registered result.
- flags  out  4  registered {N,Z,C,V}; flags[3]=N, flags[0]=V.

## Operation
- Op encoding:
  - 0 ADD a+b
  - 1 SUB a-b
  - 2 NOT ~a
  - 3 AND
  - 4 ORR
  - 5 EOR
  - 6 LSL a<<shamt
  - 7 LSR a>>shamt (logical)
  - 8 ASR (sign-fill)
  - 9 ROR (rotate right)
  - 10 MUL: low WIDTH bits of a*b
  - 11–15: pass a
- N = out[WIDTH-1]; Z = (out==0), for every op.
- C rules:
  - ADD: carry-out of bit WIDTH-1.
  - SUB: no-borrow (1 when a ≥ b unsigned).
  - LSL/LSR/ASR: last bit shifted out; 0 when shamt==0.
  - ROR: out[WIDTH-1]; 0 when shamt==0.
  - MUL: 1 when the upper WIDTH bits of the 2·WIDTH product are nonzero.
  - All other ops: 0.
- V rules:
  - ADD: signed overflow (operand signs equal, result sign differs).
  - SUB: operand signs differ, result sign differs from a.
  - All other ops: 0.
- All arithmetic is modulo 2^WIDTH. Shift amount range is 0..WIDTH-1; no oversize shifts are possible.
- FSM states:
  - IDLE (reset state): in_ready=1, out_valid=0.
  - BUSY: MUL iterating, in_ready=0, out_valid=0; step counter runs 0..WIDTH-1.
  - HOLD: out_valid=1; in_ready = out_ready.
- FSM transitions:
  - IDLE/HOLD, accept (in_valid & in_ready) of a non-MUL op → HOLD with new out/flags.
  - IDLE/HOLD, accept of MUL → BUSY. Load multiplicand, multiplier and a 2·WIDTH accumulator; counter=0.
  - BUSY: each cycle, one shift-add step and counter+1. At the edge where counter==WIDTH-1, go to HOLD with out/flags written.
  - HOLD, out_ready & !in_valid → IDLE.
  - HOLD, !out_ready → stay. out/flags held stable; inputs ignored.
- Operands are captured at accept. Later changes to a/b/op/shamt do not affect an in-flight MUL.

## Timing
- Reset (rst high at an edge):
  - state=IDLE, out=0, flags=0, out_valid=0, counter=0; in-flight MUL discarded.
  - While rst is high, in_valid is ignored and in_ready=0.
  - in_ready=1 in the first cycle after rst deasserts.
- Single-cycle ops: accept at edge E → out_valid=1 with result after E (latency 1).
- MUL: accept at edge E → out_valid=1 after edge E+WIDTH (latency WIDTH; 8 cycles at default).
- Throughput: one single-cycle op per clock with out_ready held high. A new accept in HOLD overwrites out/flags on the same edge that the old result is consumed.
- out_valid never drops without out_ready=1 at an edge, except on reset.

## Test plan
- Reset mid-MUL: accept MUL, assert rst on the 3rd BUSY cycle → next cycle out_valid=0, out=0, flags=0, in_ready=1 once rst drops; no late result appears.
- ADD, WIDTH=8, a=0x7F, b=0x01 → one cycle later out=0x80, flags=4'b1001. SUB a=b=0x05 → out=0x00, flags=4'b0110.
- Shifts:
  - LSL a=0x81, shamt=1 → out=0x02, flags=4'b0010.
  - ASR a=0x80, shamt=3 → out=0xF0, flags=4'b1000.
  - ROR a=0x01, shamt=1 → out=0x80, flags=4'b1010.
- MUL a=0x10, b=0x11 → in_ready=0 for 8 cycles; out_valid exactly 8 cycles after accept; out=0x10, flags=4'b0010. Changing a/b during BUSY has no effect.
- Backpressure: stream ADDs 1+1, 2+2, 3+3 with out_ready low for 4 cycles after the first result → out held at 0x02, in_ready=0. Results 0x02, 0x04, 0x06 then delivered in order with none lost or duplicated.
- WIDTH=16 instance: SUB 0x0000-0x0001 → out=0xFFFF, flags=4'b1000. MUL 0x0100·0x0100 → out=0x0000, flags=4'b0110, latency 16.
